// File: rtl/zzlab_env_axil_master_if.sv
// AXI4-Lite bus bundle between an initiator (master modport) and a register slave.
// Channel names follow the AXI signal names so they line up with s_axi_control ports.
interface zzlab_env_axil_master_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [ADDR_WIDTH-1:0]     ARADDR;
    logic                      RVALID;
    logic                      RREADY;
    logic [DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/zzlab_env_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI-Lite transfer out, one
// response back, with a per-transaction timeout so a hung slave cannot wedge the requester.
module zzlab_env_axil_master #(
    parameter int C_M_AXI_CONTROL_ADDR_WIDTH = 6,
    parameter int C_M_AXI_CONTROL_DATA_WIDTH = 32,
    parameter int C_TIMEOUT                  = 1024
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic                                    cmd_write,
    input  logic [C_M_AXI_CONTROL_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_CONTROL_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_CONTROL_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [C_M_AXI_CONTROL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                              rsp_resp,
    output logic                                    rsp_timeout,
    zzlab_env_axil_master_if.master                 m_axi_control
);
    localparam int AW     = C_M_AXI_CONTROL_ADDR_WIDTH;
    localparam int DW     = C_M_AXI_CONTROL_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int CNT_W  = ($clog2(C_TIMEOUT + 1) > 0) ? $clog2(C_TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (C_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(C_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);
    localparam logic [AW-1:0]    ADDR_MASK = ~AW'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT_B,
        S_WAIT_R,
        S_RSP
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q, w_pend_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CNT_W-1:0]  cnt_sat;
    logic              expire;
    logic              abort;
    logic              aw_done;
    logic              w_done;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            aw_pend_q     <= 1'b0;
            w_pend_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            aw_pend_q     <= aw_pend_d;
            w_pend_q      <= w_pend_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // The counter saturates at C_TIMEOUT; expiry fires on the cycle it would reach it.
    assign cnt_sat = (cnt_q == TO_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign expire  = TO_EN && (cnt_q == TO_LAST);
    assign aw_done = !aw_pend_q || m_axi_control.AWREADY;
    assign w_done  = !w_pend_q  || m_axi_control.WREADY;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        aw_pend_d     = aw_pend_q;
        w_pend_d      = w_pend_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        abort         = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr & ADDR_MASK;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cnt_d       = '0;
                    if (cmd_write) begin
                        state_d   = S_WR;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d   = S_RD;
                    end
                end
            end
            S_WR: begin
                cnt_d = cnt_sat;
                if (expire) begin
                    abort = 1'b1;
                end else begin
                    // AW and W complete independently; leave once both have handshaken.
                    aw_pend_d = aw_pend_q && !m_axi_control.AWREADY;
                    w_pend_d  = w_pend_q  && !m_axi_control.WREADY;
                    if (aw_done && w_done) begin
                        state_d = S_WAIT_B;
                    end
                end
            end
            S_RD: begin
                cnt_d = cnt_sat;
                if (expire) begin
                    abort = 1'b1;
                end else if (m_axi_control.ARREADY) begin
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_B: begin
                cnt_d = cnt_sat;
                if (m_axi_control.BVALID) begin
                    state_d       = S_RSP;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi_control.BRESP;
                    rsp_timeout_d = 1'b0;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_sat;
                if (m_axi_control.RVALID) begin
                    state_d       = S_RSP;
                    rsp_rdata_d   = m_axi_control.RDATA;
                    rsp_resp_d    = m_axi_control.RRESP;
                    rsp_timeout_d = 1'b0;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                aw_pend_d   = 1'b0;
                w_pend_d    = 1'b0;
            end
        endcase

        if (abort) begin
            state_d       = S_RSP;
            aw_pend_d     = 1'b0;
            w_pend_d      = 1'b0;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = (state_q == S_RSP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    // All AXI VALID/READY outputs come straight from flops or decoded state.
    assign m_axi_control.AWVALID = aw_pend_q;
    assign m_axi_control.AWADDR  = addr_q;
    assign m_axi_control.WVALID  = w_pend_q;
    assign m_axi_control.WDATA   = wdata_q;
    assign m_axi_control.WSTRB   = wstrb_q;
    assign m_axi_control.BREADY  = (state_q == S_WAIT_B);
    assign m_axi_control.ARVALID = (state_q == S_RD);
    assign m_axi_control.ARADDR  = addr_q;
    assign m_axi_control.RREADY  = (state_q == S_WAIT_R);
endmodule
